pio_key_irq: RTL and testbench

Avalon-MM slave input PIO for push-buttons and switches: the receive-direction counterpart of the LED output PIO on the Qsys system bus. Synchronises and debounces `WIDTH` external inputs, exposes the debounced level, latches selected edges into a write-1-to-clear capture register, and raises a level-sensitive interrupt to the Nios II for unmasked captured edges.

---
 rtl/pio_pkg.sv | 20 ++
 rtl/pio_debounce.sv | 60 ++++++
 rtl/pio_key_irq.sv | 92 +++++++++
 tb/tb_pio_key_irq.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared register map and edge-selection encodings for the Avalon-MM PIO blocks
// (key/switch input PIO and LED output PIO).
package pio_pkg;

   localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
   localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
   localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

   localparam int PIO_EDGE_RISING  = 0;
   localparam int PIO_EDGE_FALLING = 1;
   localparam int PIO_EDGE_ANY     = 2;

   typedef enum logic [1:0] {
      EDGE_RISING  = 2'd0,
      EDGE_FALLING = 2'd1,
      EDGE_ANY     = 2'd2
   } pio_edge_e;

endpackage

// File: rtl/pio_debounce.sv
// One input bit: two-flop synchroniser, stability counter and debounced state.
// db_next exposes the value db will take on the coming edge, for edge detection.
module pio_debounce #(
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic IDLE_LEVEL      = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in_bit,
   output logic db,
   output logic db_next
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      (DEBOUNCE_CYCLES > 0) ? CNT_W'(DEBOUNCE_CYCLES - 1) : '0;

   logic [1:0]       sync_q;
   logic             sync_out;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   assign sync_out = sync_q[1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {IDLE_LEVEL, IDLE_LEVEL};
      end else begin
         sync_q <= {sync_q[0], in_bit};
      end
   end

   // Count consecutive differing clocks; the last one in the window accepts the new level.
   always_comb begin
      cnt_next = cnt;
      db_next  = db;
      if (DEBOUNCE_CYCLES == 0) begin
         cnt_next = '0;
         db_next  = sync_out;
      end else if (sync_out == db) begin
         cnt_next = '0;
      end else if (cnt == CNT_LAST) begin
         cnt_next = '0;
         db_next  = sync_out;
      end else begin
         cnt_next = cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         db  <= IDLE_LEVEL;
      end else begin
         cnt <= cnt_next;
         db  <= db_next;
      end
   end

endmodule

// File: rtl/pio_key_irq.sv
// Avalon-MM input PIO for keys/switches: debounced level, RW1C edge capture
// and a level interrupt for unmasked captured edges.
module pio_key_irq
   import pio_pkg::*;
#(
   parameter int               WIDTH           = 4,
   parameter int               DEBOUNCE_CYCLES = 50000,
   parameter int               EDGE_TYPE       = 1,
   parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] db;
   logic [WIDTH-1:0] db_next;
   logic [WIDTH-1:0] edge_hit;
   logic [WIDTH-1:0] cap_clr;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_cap;
   logic             wr_en;
   logic             unused_wdata;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         pio_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_LEVEL      (IDLE_LEVEL[gi])
         ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .in_bit  (in_port[gi]),
            .db      (db[gi]),
            .db_next (db_next[gi])
         );
      end
   endgenerate

   assign wr_en        = chipselect && !write_n;
   assign unused_wdata = ^writedata;

   always_comb begin
      edge_hit = '0;
      case (EDGE_TYPE)
         PIO_EDGE_RISING:  edge_hit = ~db & db_next;
         PIO_EDGE_FALLING: edge_hit = db & ~db_next;
         default:          edge_hit = db ^ db_next;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask <= '0;
      end else if (wr_en && address == PIO_ADDR_IRQMASK) begin
         irq_mask <= writedata[WIDTH-1:0];
      end
   end

   assign cap_clr = (wr_en && address == PIO_ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

   // A fresh edge is ORed in after the clear, so a same-cycle clear never loses it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_cap <= '0;
      end else begin
         edge_cap <= (edge_cap & ~cap_clr) | edge_hit;
      end
   end

   assign irq = |(edge_cap & irq_mask);

   always_comb begin
      readdata = '0;
      if (chipselect) begin
         case (address)
            PIO_ADDR_DATA:    readdata[WIDTH-1:0] = db;
            PIO_ADDR_IRQMASK: readdata[WIDTH-1:0] = irq_mask;
            PIO_ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_cap;
            default:          readdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_pio_key_irq.sv
// Directed bench for pio_key_irq: three instances (falling, any, rising edge)
// with a short debounce window, sharing one Avalon bus.
module tb_pio_key_irq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_a;
   logic [3:0]  in_b;
   logic [31:0] rd0, rd1, rd2;
   logic        irq0, irq1, irq2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pio_key_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(1)) u_fall (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_a),
      .readdata(rd0), .irq(irq0));

   pio_key_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(2)) u_any (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_b),
      .readdata(rd1), .irq(irq1));

   pio_key_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(0)) u_rise (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_b),
      .readdata(rd2), .irq(irq2));

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Bus write, sampled on the next rising edge.
   task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = addr;
      writedata  = data;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic busRead(input logic [1:0] addr);
      chipselect = 1'b1;
      write_n    = 1'b1;
      address    = addr;
      #1;
   endtask

   initial begin
      reset_n    = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 2'd0;
      writedata  = '0;
      in_a       = 4'hF;
      in_b       = 4'hF;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // Reset state
      busRead(2'd0); checkOutput("reset_data", rd0, 32'hF);
      checkOutput("reset_data_rise", rd2, 32'hF);
      busRead(2'd1); checkOutput("reset_rsvd", rd0, 32'h0);
      busRead(2'd2); checkOutput("reset_mask", rd0, 32'h0);
      busRead(2'd3); checkOutput("reset_cap", rd0, 32'h0);
      checkOutput("reset_irq", {31'd0, irq0}, 32'h0);

      // Press bit 0: db changes exactly 17 edges after the change is seen
      tick();
      in_a[0] = 1'b0;
      ticks(17);
      busRead(2'd0); checkOutput("press_data_early", rd0, 32'hF);
      tick();
      busRead(2'd0); checkOutput("press_data", rd0, 32'hE);
      busRead(2'd3); checkOutput("press_cap", rd0, 32'h1);
      checkOutput("press_irq_masked", {31'd0, irq0}, 32'h0);
      applyStimulus(2'd2, 32'h1);
      checkOutput("unmask_irq", {31'd0, irq0}, 32'h1);
      busRead(2'd2); checkOutput("mask_rd", rd0, 32'h1);

      // RW1C: write 0 is ignored, write 1 clears
      applyStimulus(2'd3, 32'h0);
      busRead(2'd3); checkOutput("cap_w0", rd0, 32'h1);
      applyStimulus(2'd3, 32'h1);
      busRead(2'd3); checkOutput("cap_clr", rd0, 32'h0);
      checkOutput("clr_irq", {31'd0, irq0}, 32'h0);

      // 15-cycle glitch on bit 1 never reaches db
      tick();
      in_a[1] = 1'b0;
      ticks(15);
      in_a[1] = 1'b1;
      ticks(25);
      busRead(2'd0); checkOutput("glitch_data", rd0, 32'hE);
      busRead(2'd3); checkOutput("glitch_cap", rd0, 32'h0);

      // Release bit 0: rising edge not captured by falling-type instance
      in_a[0] = 1'b1;
      ticks(20);
      busRead(2'd0); checkOutput("release_data", rd0, 32'hF);
      busRead(2'd3); checkOutput("release_cap", rd0, 32'h0);

      // Clear lands on the same edge as a new falling edge: set wins
      tick();
      in_a[0] = 1'b0;
      ticks(17);
      busRead(2'd3); checkOutput("collide_pre", rd0, 32'h0);
      applyStimulus(2'd3, 32'h1);
      busRead(2'd3); checkOutput("collide_cap", rd0, 32'h1);
      checkOutput("collide_irq", {31'd0, irq0}, 32'h1);
      applyStimulus(2'd3, 32'h1);
      checkOutput("collide_clr_irq", {31'd0, irq0}, 32'h0);
      in_a[0] = 1'b1;
      ticks(20);
      applyStimulus(2'd2, 32'h0);

      // Edge type any vs rising on bit 2
      in_b[2] = 1'b0;
      ticks(20);
      busRead(2'd3); checkOutput("any_press", rd1, 32'h4);
      checkOutput("rise_press", rd2, 32'h0);
      busRead(2'd0); checkOutput("rise_data", rd2, 32'hB);
      applyStimulus(2'd3, 32'h4);
      busRead(2'd3); checkOutput("any_clr", rd1, 32'h0);
      in_b[2] = 1'b1;
      ticks(20);
      busRead(2'd3); checkOutput("any_release", rd1, 32'h4);
      checkOutput("rise_release", rd2, 32'h4);
      checkOutput("rise_irq_masked", {31'd0, irq2}, 32'h0);

      // Reset halfway through a debounce count on bit 3
      tick();
      in_a[3] = 1'b0;
      ticks(8);
      reset_n = 1'b0;
      #1;
      busRead(2'd0); checkOutput("rst_async_data", rd0, 32'hF);
      busRead(2'd3); checkOutput("rst_async_cap", rd1, 32'h0);
      ticks(2);
      in_a[3] = 1'b1;
      tick();
      reset_n = 1'b1;
      ticks(25);
      busRead(2'd0); checkOutput("post_rst_data", rd0, 32'hF);
      busRead(2'd3); checkOutput("post_rst_cap", rd0, 32'h0);

      // Fresh full-length press still accepted
      tick();
      in_a[3] = 1'b0;
      ticks(18);
      busRead(2'd0); checkOutput("repress_data", rd0, 32'h7);
      busRead(2'd3); checkOutput("repress_cap", rd0, 32'h8);
      applyStimulus(2'd2, 32'h8);
      checkOutput("repress_irq", {31'd0, irq0}, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
